hv_abist_rsp: RTL and testbench

HV-side BIST responder: the far end of the analog-BIST stimulus lines driven by the HV BIST sequencer. In functional mode it synchronizes the raw analog fault comparators and ADC words and forwards them to the sequencer's detect inputs. In emulation mode it answers each stimulus line with a digitally timed fault flag, or ADC code, so the sequencer can be exercised without analog silicon. A per-item fail mask forces non-response, so the sequencer's fail path can be exercised.

---
 rtl/hv_abist_rsp.sv | 152 +++++++++++++++
 tb/tb_hv_abist_rsp.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_abist_rsp.sv
// HV-side BIST responder: forwards synchronized analog fault flags and ADC words,
// or emulates timed fault/ADC responses to the BIST sequencer's stimulus lines.
module hv_abist_rsp #(
  parameter int                CLK_M        = 48,
  parameter int                ADC_DW       = 10,
  parameter int                RSP_DLY_CYC  = 8,
  parameter int                REL_DLY_CYC  = 4,
  parameter logic [ADC_DW-1:0] ADC_EMU_CODE = 10'h200
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rsp_mode,
  input  logic [5:0]        i_rsp_fail_mask,
  input  logic [5:0]        i_bist_stim,
  input  logic [4:0]        i_ana_flt,
  input  logic [ADC_DW-1:0] i_ana_adc_data1,
  input  logic [ADC_DW-1:0] i_ana_adc_data2,
  output logic              o_hv_vcc_ov,
  output logic              o_hv_ot,
  output logic              o_hv_desat_flt,
  output logic              o_hv_oc,
  output logic              o_hv_scp_flt,
  output logic [ADC_DW-1:0] o_hv_adc_data1,
  output logic [ADC_DW-1:0] o_hv_adc_data2,
  output logic              o_rsp_busy,
  output logic [2:0]        o_rsp_item,
  output logic              o_rsp_err
);

  localparam int CW = $clog2(CLK_M + 1);

  typedef enum logic [2:0] {S_IDLE, S_DLY, S_ASSERT, S_RELEASE, S_MASKED} state_t;

  state_t            state_q, state_d;
  logic [2:0]        item_q, item_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [5:0]        stimIn_q, stimFf_q;
  logic [4:0]        fltS1_q, fltS2_q;
  logic [ADC_DW-1:0] adc1_q, adc2_q;
  logic [5:0]        rise, fall, itemBit;
  logic [2:0]        lowItem;
  logic              multiRise, active;
  logic [4:0]        flagOut;

  // Edges are taken after the stimulus register, so the FSM reacts one
  // cycle after the stimulus is first sampled.
  assign rise      = stimIn_q & ~stimFf_q;
  assign fall      = ~stimIn_q & stimFf_q;
  assign multiRise = (rise & (rise - 6'd1)) != 6'd0;
  assign itemBit   = 6'b1 << item_q;
  assign active    = (state_q == S_ASSERT) || (state_q == S_RELEASE);

  always_comb begin
    lowItem = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (rise[i]) lowItem = 3'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      item_q   <= 3'd7;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      stimIn_q <= '0;
      stimFf_q <= '0;
      fltS1_q  <= '0;
      fltS2_q  <= '0;
      adc1_q   <= '0;
      adc2_q   <= '0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      stimIn_q <= i_bist_stim;
      stimFf_q <= stimIn_q;
      fltS1_q  <= i_ana_flt;
      fltS2_q  <= fltS1_q;
      adc1_q   <= i_ana_adc_data1;
      adc2_q   <= i_ana_adc_data2;
    end
  end

  // Only the captured item steers the FSM; other rises can only flag an error.
  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (!i_rsp_mode) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (multiRise || ((state_q != S_IDLE) && ((rise & ~itemBit) != 6'd0))) err_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (rise != 6'd0) begin
            item_d  = lowItem;
            cnt_d   = '0;
            state_d = ((i_rsp_fail_mask & (6'b1 << lowItem)) != 6'd0) ? S_MASKED : S_DLY;
          end
        end
        S_DLY: begin
          if ((fall & itemBit) != 6'd0)            state_d = S_IDLE;
          else if (cnt_q == CW'(RSP_DLY_CYC - 1)) state_d = S_ASSERT;
          else                                     cnt_d   = cnt_q + CW'(1);
        end
        S_ASSERT: begin
          if ((fall & itemBit) != 6'd0) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end
        end
        S_RELEASE: begin
          if (cnt_q == CW'(REL_DLY_CYC - 1)) state_d = S_IDLE;
          else                               cnt_d   = cnt_q + CW'(1);
        end
        S_MASKED: begin
          if ((fall & itemBit) != 6'd0) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Mode steers the outputs directly so a mode drop switches paths immediately.
  always_comb begin
    if (!i_rsp_mode) begin
      flagOut        = fltS2_q;
      o_hv_adc_data1 = adc1_q;
      o_hv_adc_data2 = adc2_q;
    end else begin
      flagOut        = active ? itemBit[4:0] : 5'd0;
      o_hv_adc_data1 = (active && (item_q == 3'd5)) ? ADC_EMU_CODE : '0;
      o_hv_adc_data2 = (active && (item_q == 3'd5)) ? ADC_EMU_CODE : '0;
    end
  end

  assign o_hv_vcc_ov    = flagOut[0];
  assign o_hv_ot        = flagOut[1];
  assign o_hv_desat_flt = flagOut[2];
  assign o_hv_oc        = flagOut[3];
  assign o_hv_scp_flt   = flagOut[4];
  assign o_rsp_busy     = (state_q != S_IDLE);
  assign o_rsp_item     = (state_q == S_IDLE) ? 3'd7 : item_q;
  assign o_rsp_err      = err_q;

endmodule

// File: tb/tb_hv_abist_rsp.sv
// Testbench for hv_abist_rsp: timed expectations are queued when stimulus is
// driven and compared by a negedge monitor when their cycle comes round.
module tb_hv_abist_rsp;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [5:0] mask;
  logic [5:0] stim;
  logic [4:0] anaFlt;
  logic [9:0] anaAdc1, anaAdc2;
  logic       hvVccOv, hvOt, hvDesat, hvOc, hvScp;
  logic [9:0] hvAdc1, hvAdc2;
  logic       busy;
  logic [2:0] item;
  logic       err;

  int cyc = 0;
  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [9:0] exp;
    string      tag;
  } sb_t;

  typedef struct {
    logic [5:0] stim;
    logic [5:0] mask;
    logic [4:0] expFlags;
    logic [9:0] expAdc;
    logic [2:0] expItem;
    logic       expBusyLate;
  } vec_t;

  sb_t  sbQ[$];
  vec_t vecs[9];

  hv_abist_rsp dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rsp_mode      (mode),
    .i_rsp_fail_mask (mask),
    .i_bist_stim     (stim),
    .i_ana_flt       (anaFlt),
    .i_ana_adc_data1 (anaAdc1),
    .i_ana_adc_data2 (anaAdc2),
    .o_hv_vcc_ov     (hvVccOv),
    .o_hv_ot         (hvOt),
    .o_hv_desat_flt  (hvDesat),
    .o_hv_oc         (hvOc),
    .o_hv_scp_flt    (hvScp),
    .o_hv_adc_data1  (hvAdc1),
    .o_hv_adc_data2  (hvAdc2),
    .o_rsp_busy      (busy),
    .o_rsp_item      (item),
    .o_rsp_err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] getOut(int sel);
    case (sel)
      0:       return {9'd0, hvVccOv};
      1:       return {9'd0, hvOt};
      2:       return {9'd0, hvDesat};
      3:       return {9'd0, hvOc};
      4:       return {9'd0, hvScp};
      5:       return hvAdc1;
      6:       return hvAdc2;
      7:       return {9'd0, busy};
      8:       return {7'd0, item};
      9:       return {9'd0, err};
      10:      return {5'd0, hvScp, hvOc, hvDesat, hvOt, hvVccOv};
      default: return 10'h3FF;
    endcase
  endfunction

  function automatic string selName(int sel);
    case (sel)
      0:       return "vcc_ov";
      1:       return "ot";
      2:       return "desat";
      3:       return "oc";
      4:       return "scp";
      5:       return "adc1";
      6:       return "adc2";
      7:       return "busy";
      8:       return "item";
      9:       return "err";
      10:      return "flags";
      default: return "?";
    endcase
  endfunction

  task automatic checkOutput(string nm, logic [9:0] act, logic [9:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s cyc %0d: actual %h required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic expectAt(int c, int sel, logic [9:0] v, string tag);
    sb_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(logic m, logic [5:0] mk, logic [5:0] s);
    mode = m;
    mask = mk;
    stim = s;
  endtask

  task automatic waitUntil(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pop every expectation that is due at this cycle and compare it.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      sb_t e;
      e = sbQ.pop_front();
      if (e.cyc < cyc) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s %s: expectation for cyc %0d never checked", e.tag, selName(e.sel), e.cyc);
      end else begin
        checkOutput($sformatf("%s %s", e.tag, selName(e.sel)), getOut(e.sel), e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int j;

    vecs[0] = '{6'h01, 6'h00, 5'h01, 10'h000, 3'd0, 1'b1};
    vecs[1] = '{6'h02, 6'h00, 5'h02, 10'h000, 3'd1, 1'b1};
    vecs[2] = '{6'h04, 6'h00, 5'h04, 10'h000, 3'd2, 1'b1};
    vecs[3] = '{6'h08, 6'h00, 5'h08, 10'h000, 3'd3, 1'b1};
    vecs[4] = '{6'h10, 6'h00, 5'h10, 10'h000, 3'd4, 1'b1};
    vecs[5] = '{6'h20, 6'h00, 5'h00, 10'h200, 3'd5, 1'b1};
    vecs[6] = '{6'h20, 6'h20, 5'h00, 10'h000, 3'd5, 1'b0};
    vecs[7] = '{6'h01, 6'h3E, 5'h01, 10'h000, 3'd0, 1'b1};
    vecs[8] = '{6'h02, 6'h02, 5'h00, 10'h000, 3'd1, 1'b0};

    rst     = 1'b1;
    anaFlt  = '0;
    anaAdc1 = '0;
    anaAdc2 = '0;
    applyStimulus(1'b0, 6'h00, 6'h00);
    waitUntil(3);

    // Reset values
    expectAt(3, 7, 10'd0, "reset");
    expectAt(3, 8, 10'd7, "reset");
    expectAt(3, 9, 10'd0, "reset");
    expectAt(3, 10, 10'd0, "reset");
    expectAt(3, 5, 10'd0, "reset");
    rst = 1'b0;
    waitUntil(5);

    // Pass mode: flag through the synchronizer, ADC words after one register
    k = cyc;
    anaFlt  = 5'h02;
    anaAdc1 = 10'h1FC;
    anaAdc2 = 10'h0A5;
    applyStimulus(1'b0, 6'h00, 6'h01);
    expectAt(k + 1, 1, 10'd0, "pass");
    expectAt(k + 1, 5, 10'h1FC, "pass");
    expectAt(k + 1, 6, 10'h0A5, "pass");
    for (int c = k + 3; c <= k + 11; c++) begin
      expectAt(c, 1, 10'd1, "pass");
      if (c == k + 5) expectAt(c, 7, 10'd0, "pass");
    end
    expectAt(k + 13, 1, 10'd0, "pass");
    waitUntil(k + 10);
    anaFlt = 5'h00;
    waitUntil(k + 14);
    stim = 6'h00;

    // Emulation: analog inputs are live but must be ignored
    anaFlt  = 5'h1F;
    anaAdc1 = 10'h3FF;
    anaAdc2 = 10'h155;
    applyStimulus(1'b1, 6'h00, 6'h00);
    waitUntil(cyc + 4);

    for (int i = 0; i < 9; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      k = cyc;
      j = k + 14;
      applyStimulus(1'b1, vecs[i].mask, vecs[i].stim);
      expectAt(k + 1, 7, 10'd0, t);
      expectAt(k + 1, 8, 10'd7, t);
      expectAt(k + 2, 7, 10'd1, t);
      expectAt(k + 2, 8, {7'd0, vecs[i].expItem}, t);
      expectAt(k + 9, 10, 10'd0, t);
      expectAt(k + 10, 10, {5'd0, vecs[i].expFlags}, t);
      expectAt(k + 10, 5, vecs[i].expAdc, t);
      expectAt(k + 10, 6, vecs[i].expAdc, t);
      expectAt(k + 10, 7, 10'd1, t);
      expectAt(j + 5, 10, {5'd0, vecs[i].expFlags}, t);
      expectAt(j + 5, 5, vecs[i].expAdc, t);
      expectAt(j + 5, 7, {9'd0, vecs[i].expBusyLate}, t);
      expectAt(j + 6, 10, 10'd0, t);
      expectAt(j + 6, 5, 10'd0, t);
      expectAt(j + 6, 7, 10'd0, t);
      expectAt(j + 6, 8, 10'd7, t);
      expectAt(j + 6, 9, 10'd0, t);
      waitUntil(j);
      stim = 6'h00;
      waitUntil(j + 8);
    end
    mask = 6'h00;

    // Stimulus dropped while still in the response delay
    k = cyc;
    stim = 6'h04;
    expectAt(k + 5, 7, 10'd1, "abort");
    expectAt(k + 6, 7, 10'd0, "abort");
    expectAt(k + 6, 9, 10'd0, "abort");
    expectAt(k + 9, 2, 10'd0, "abort");
    expectAt(k + 10, 2, 10'd0, "abort");
    expectAt(k + 11, 2, 10'd0, "abort");
    waitUntil(k + 4);
    stim = 6'h00;
    waitUntil(k + 13);

    // Two bits rising together; a one-cycle mode drop clears the error
    anaFlt = 5'h15;
    waitUntil(cyc + 3);
    k = cyc;
    stim = 6'h06;
    expectAt(k + 1, 9, 10'd0, "multi");
    expectAt(k + 2, 8, 10'd1, "multi");
    expectAt(k + 2, 9, 10'd1, "multi");
    expectAt(k + 10, 1, 10'd1, "multi");
    expectAt(k + 10, 2, 10'd0, "multi");
    expectAt(k + 11, 1, 10'd0, "modedrop");
    expectAt(k + 11, 2, 10'd1, "modedrop");
    expectAt(k + 12, 9, 10'd0, "modedrop");
    expectAt(k + 12, 7, 10'd0, "modedrop");
    expectAt(k + 14, 9, 10'd0, "modedrop");
    expectAt(k + 14, 7, 10'd0, "modedrop");
    waitUntil(k + 11);
    mode = 1'b0;
    waitUntil(k + 12);
    mode = 1'b1;
    stim = 6'h00;
    waitUntil(k + 16);

    // Late rise on another item, then reset while item 3 is asserted
    k = cyc;
    stim = 6'h08;
    expectAt(k + 2, 8, 10'd3, "late");
    expectAt(k + 5, 9, 10'd0, "late");
    expectAt(k + 6, 9, 10'd1, "late");
    expectAt(k + 6, 8, 10'd3, "late");
    expectAt(k + 10, 3, 10'd1, "late");
    expectAt(k + 10, 0, 10'd0, "late");
    expectAt(k + 11, 3, 10'd1, "late");
    expectAt(k + 12, 3, 10'd0, "rstmid");
    expectAt(k + 12, 7, 10'd0, "rstmid");
    expectAt(k + 12, 8, 10'd7, "rstmid");
    expectAt(k + 12, 9, 10'd0, "rstmid");
    expectAt(k + 14, 7, 10'd0, "rstmid");
    expectAt(k + 14, 8, 10'd7, "rstmid");
    waitUntil(k + 4);
    stim = 6'h09;
    waitUntil(k + 11);
    rst = 1'b1;
    waitUntil(k + 12);
    rst  = 1'b0;
    stim = 6'h00;
    waitUntil(k + 18);

    while (sbQ.size() > 0) begin
      sb_t e;
      e = sbQ.pop_front();
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL %s %s: expectation for cyc %0d left unchecked", e.tag, selName(e.sel), e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
